// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned ADSIZE_DEFAULT = 5;
  localparam int unsigned DASIZE_DEFAULT = 32;
  localparam int unsigned DEPTH          = 2 ** ADSIZE_DEFAULT;
  localparam int unsigned BYTES          = DASIZE_DEFAULT / 8;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_DW    = 256;
  localparam int unsigned MAX_BYTES = MAX_DW / 8;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]    old_data,
                                                   input logic [MAX_DW-1:0]    new_data,
                                                   input logic [MAX_BYTES-1:0] mask);
    logic [MAX_DW-1:0] res;
    res = old_data;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (mask[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_write_merge.sv
// Per-register, per-byte merge of all write ports; later ports override earlier ones.
module rf_write_merge
  import reg_file_pkg::*;
#(
  parameter int unsigned ADSize   = ADSIZE_DEFAULT,
  parameter int unsigned DASize   = DASIZE_DEFAULT,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned Depth   = 2 ** ADSize,
  localparam int unsigned Bytes   = DASize / 8
) (
  input  logic [Depth-1:0][DASize-1:0] cur_data,
  input  logic [NWR-1:0]               wr_acc,
  input  logic [NWR*ADSize-1:0]        waddr,
  input  logic [NWR*DASize-1:0]        wdata,
  input  logic [NWR*Bytes-1:0]         wmask,
  output logic [Depth-1:0][DASize-1:0] next_data,
  output logic [Depth-1:0]             next_we
);

  always_comb begin
    next_data = cur_data;
    next_we   = '0;
    for (int r = 0; r < Depth; r++) begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_acc[i] && (waddr[i*ADSize +: ADSize] == ADSize'(r)) && !(ZERO_REG && r == 0)) begin
          next_data[r] = DASize'(byte_merge(MAX_DW'(next_data[r]),
                                            MAX_DW'(wdata[i*DASize +: DASize]),
                                            MAX_BYTES'(wmask[i*Bytes +: Bytes])));
          next_we[r]   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with byte-masked writes, registered reads and a bulk-clear engine.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned ADSize   = ADSIZE_DEFAULT,
  parameter int unsigned DASize   = DASIZE_DEFAULT,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      Read,
  input  logic [NWR-1:0]            Write,
  input  logic [NWR*ADSize-1:0]     Write_ADDR,
  input  logic [NWR*DASize-1:0]     DIN,
  input  logic [NWR*DASize/8-1:0]   WMASK,
  input  logic [NRD*ADSize-1:0]     Read_ADDR,
  output logic [NRD*DASize-1:0]     OUT,
  output logic                      OUT_valid,
  input  logic                      clr_req,
  output logic                      clr_busy
);

  localparam int unsigned Depth = 2 ** ADSize;

  clr_state_e                    state_q, state_d;
  logic [ADSize-1:0]             ptr_q, ptr_d;
  logic [Depth-1:0][DASize-1:0]  mem_q, next_data;
  logic [Depth-1:0]              next_we;
  logic [NRD-1:0][DASize-1:0]    out_q, rd_data;
  logic                          out_valid_q;
  logic                          clr_start, ops_ok, rd_acc;
  logic [NWR-1:0]                wr_acc;

  assign clr_busy  = (state_q == StClear);
  // A clear request in idle suppresses any access presented alongside it.
  assign clr_start = (state_q == StIdle) && clr_req;
  assign ops_ok    = enable && !clr_busy && !clr_start;
  assign wr_acc    = Write & {NWR{ops_ok}};
  assign rd_acc    = ops_ok && Read;

  rf_write_merge #(
    .ADSize   (ADSize),
    .DASize   (DASize),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_merge (
    .cur_data  (mem_q),
    .wr_acc    (wr_acc),
    .waddr     (Write_ADDR),
    .wdata     (DIN),
    .wmask     (WMASK),
    .next_data (next_data),
    .next_we   (next_we)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        ptr_d = ptr_q + ADSize'(1);
        if (ptr_q == ADSize'(Depth - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (clr_busy) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int r = 0; r < Depth; r++) begin
        if (next_we[r]) mem_q[r] <= next_data[r];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
`ifdef RF_BYPASS_EN
      rd_data[p] = next_data[Read_ADDR[p*ADSize +: ADSize]];
`else
      rd_data[p] = mem_q[Read_ADDR[p*ADSize +: ADSize]];
`endif
      if (ZERO_REG && (Read_ADDR[p*ADSize +: ADSize] == '0)) rd_data[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_acc;
      if (rd_acc) out_q <= rd_data;
    end
  end

  assign OUT       = out_q;
  assign OUT_valid = out_valid_q;

endmodule
